turn_pattern_gen: RTL and testbench
===================================

# turn_pattern_gen

Pattern sequencer directly upstream of the tail-light main FSM. It takes the FSM's channel-active flags (L, H, R) and generates the stepping pattern words that the FSM drives onto the six lamps: a 3-bit outward sweep for each turn side and a 6-bit alternating hazard flash. It contains a shared step prescaler, so the FSM only chooses which pattern reaches the lamps and never handles timing.

## Interface
- TICK_DIV, default 25_000_000: clocks per pattern step; legal range ≥1.
- CNT_W, default $clog2(TICK_DIV)+1: prescaler counter width; derived, never overridden.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- L  in  1  left channel active, from main FSM.
- H  in  1  hazard channel active, from main FSM.
- R  in  1  right channel active, from main FSM.
- left_out  out  3  left sweep word; feeds FSM left pattern input (bit0 = innermost lamp).
- right_out  out  3  right sweep word; feeds FSM right pattern input (bit0 = innermost lamp).
- haz_out  out  6  hazard word; feeds FSM hazard pattern input.
- step  out  1  one-cycle pulse on each pattern advance, for debug and bench sync.

## Operation
- Reset (async, rst_n=0): left_out=000, right_out=000, haz_out=000000, step=0, prescaler=0.
- Idle (L=H=R=0): all outputs 0; prescaler held at 0.
- Prescaler: free-runs while any of L/H/R is 1. It counts 0..TICK_DIV-1, and step=1 for the one cycle in which the count wraps to 0.
- Left/right sweep states: OFF(000) → S1(001) → S2(011) → S3(111) → OFF(000) → S1 …
  - Cycle length is 4 steps.
  - The two sides run independently, but both advance only on the shared step.
- Hazard states: HA(010101) ↔ HB(101010); alternates on each step.
- Rising L (or R), with H=0: the side loads S1 on the next clock edge, without waiting for a step. Later advances occur on step.
- Rising H: haz_out loads HA on the next clock edge. Later advances occur on step.
- Falling enable on any channel: that channel returns to all-zero on the next clock edge and holds there.
- Precedence:
  - While H=1, left_out and right_out are forced to 000, whatever L and R are.
  - On H falling with L or R still 1, that side reloads S1 on the next clock, exactly as on a fresh rising enable.
- L and R both 1: both sweeps run. If they rose together they stay in lockstep.
- Prescaler restart: when the enables go from all-0 to any-1, counting starts from 0. A channel that joins while the prescaler is already running aligns to the existing step grid (no restart).
- TICK_DIV=1: step is high every cycle while any channel is active; patterns advance every clock after the initial load.

## Timing
- All outputs are registered. There is no combinational path from L/H/R to any output.
- Enable edge → first pattern visible: 1 clock.
- Enable released → outputs zero: 1 clock.
- First advance after a channel load: TICK_DIV clocks after the prescaler (re)start, or at the next existing step if the prescaler is already running.
- step is asserted in the same cycle in which the outputs take their advanced value.
- rst_n asserted mid-sequence: outputs zero immediately (asynchronous).
- rst_n release: the synchronous block resumes from idle. A channel still held high reloads S1/HA on the first clock after release.

## Structure
- Shared package tail_light_pkg, holding:
  - sweep constants SWEEP_OFF/S1/S2/S3 (3-bit);
  - hazard constants HAZ_A=6'b010101 and HAZ_B=6'b101010;
  - the 2-bit sweep state enum.
- Sub-module step_prescaler (parameter TICK_DIV): inputs clk, rst_n, run; output step. It clears its count while run=0.
- The top instantiates one step_prescaler, two sweep state machines (left and right, same code) and one hazard toggle flop.

## Test plan
All scenarios use TICK_DIV=4.
- Reset and idle: rst_n pulsed low mid-run → all outputs 0 immediately; hold L=H=R=0 for 20 clocks → outputs stay 0 and step never pulses.
- Left sweep: L rises → next clock left_out=001; then 011, 111, 000, 001 at 4-clock intervals; right_out and haz_out stay 0.
- Hazard override: L=1, R=1 running, then H rises → next clock left_out=right_out=000 and haz_out=010101; then 101010 and 010101 every 4 clocks.
- Hazard release: H falls with R=1 → next clock haz_out=000000 and right_out=001.
- Late join: L running, R rises 2 clocks before a step → right_out=001 next clock, then advances to 011 on that same step (not 4 clocks later).
- TICK_DIV=1 build: L=1 → left_out steps 001, 011, 111, 000 on consecutive clocks, with step high every cycle.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared constants and types for the tail-light pattern sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tail_light_pkg;

  // Sweep words, bit0 = innermost lamp
  localparam logic [2:0] SWEEP_OFF = 3'b000;
  localparam logic [2:0] SWEEP_S1  = 3'b001;
  localparam logic [2:0] SWEEP_S2  = 3'b011;
  localparam logic [2:0] SWEEP_S3  = 3'b111;

  // Hazard flash words, alternate on each step
  localparam logic [5:0] HAZ_A = 6'b010101;
  localparam logic [5:0] HAZ_B = 6'b101010;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_S1  = 2'd1,
    ST_S2  = 2'd2,
    ST_S3  = 2'd3
  } sweep_state_t;

  // Next sweep state; OFF wraps back to S1 so the cycle is 4 steps long
  function automatic sweep_state_t sweep_next(input sweep_state_t st);
    case (st)
      ST_OFF:  sweep_next = ST_S1;
      ST_S1:   sweep_next = ST_S2;
      ST_S2:   sweep_next = ST_S3;
      default: sweep_next = ST_OFF;
    endcase
  endfunction

  // Lamp word driven in each sweep state
  function automatic logic [2:0] sweep_word(input sweep_state_t st);
    case (st)
      ST_OFF:  sweep_word = SWEEP_OFF;
      ST_S1:   sweep_word = SWEEP_S1;
      ST_S2:   sweep_word = SWEEP_S2;
      default: sweep_word = SWEEP_S3;
    endcase
  endfunction

endpackage

// File: rtl/turn_pattern_gen_if.sv
// Channel enables in, pattern words and step pulse out.
// Latency: n/a (wiring only).
// Backpressure: none; pattern words are level outputs sampled by the FSM.
interface turn_pattern_gen_if;
  logic       L;
  logic       H;
  logic       R;
  logic [2:0] left_out;
  logic [2:0] right_out;
  logic [5:0] haz_out;
  logic       step;

  // Main FSM side: drives enables, consumes patterns
  modport master (
    output L, H, R,
    input  left_out, right_out, haz_out, step
  );

  // Pattern generator side
  modport slave (
    input  L, H, R,
    output left_out, right_out, haz_out, step
  );
endinterface

// File: rtl/step_prescaler.sv
// Divides clk down to a step strobe every TICK_DIV cycles while run is high.
// Latency: step is a decode of the registered count, high in the last count cycle.
// Backpressure: none; count clears to 0 whenever run drops.
module step_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic step
);

  localparam int CNT_W = $clog2(TICK_DIV) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count 0..TICK_DIV-1 while running, hold at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // Users advance on the edge that wraps the count
  assign step = run && (count == LAST);

endmodule

// File: rtl/turn_pattern_gen_sweep.sv
// One 3-bit outward sweep (OFF->S1->S2->S3->OFF...) for a single turn side.
// Latency: 1 clock from enable rise to S1; later advances on adv.
// Backpressure: none; force_off or enable low clears the word next clock.
module turn_pattern_gen_sweep
  import tail_light_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       force_off,
  input  logic       adv,
  output logic [2:0] word
);

  sweep_state_t state;
  logic         live_q;   // side was enabled (and not overridden) last cycle

  // Sweep FSM with registered lamp word; a fresh enable always reloads S1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_OFF;
      live_q <= 1'b0;
      word   <= SWEEP_OFF;
    end else if (!en || force_off) begin
      state  <= ST_OFF;
      live_q <= 1'b0;
      word   <= SWEEP_OFF;
    end else if (!live_q) begin
      state  <= ST_S1;
      live_q <= 1'b1;
      word   <= SWEEP_S1;
    end else if (adv) begin
      state  <= sweep_next(state);
      word   <= sweep_word(sweep_next(state));
    end
  end

endmodule

// File: rtl/turn_pattern_gen.sv
// Generates left/right sweep words and hazard flash word for the tail-light FSM.
// Latency: 1 clock from enable edge to first pattern; advances every TICK_DIV clocks.
// Backpressure: none; outputs are free-running level words plus a step pulse.
module turn_pattern_gen
  import tail_light_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  turn_pattern_gen_if.slave    bus
);

  logic any_act;
  logic any_q;
  logic haz_live_q;
  logic pre_step;

  assign any_act = bus.L | bus.H | bus.R;

  // Remember whether anything was active, so the prescaler restarts from 0
  // on the clock that loads the first pattern rather than one clock early
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_act;
    end
  end

  // Gating with any_act clears the count the same cycle everything drops
  step_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (any_q & any_act),
    .step  (pre_step)
  );

  // Step output is registered so it lines up with the advanced pattern words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.step <= 1'b0;
    end else begin
      bus.step <= pre_step;
    end
  end

  // Hazard toggle: load HA on a fresh H, flip on each step, clear when H drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haz_live_q  <= 1'b0;
      bus.haz_out <= '0;
    end else if (!bus.H) begin
      haz_live_q  <= 1'b0;
      bus.haz_out <= '0;
    end else if (!haz_live_q) begin
      haz_live_q  <= 1'b1;
      bus.haz_out <= HAZ_A;
    end else if (pre_step) begin
      bus.haz_out <= (bus.haz_out == HAZ_A) ? HAZ_B : HAZ_A;
    end
  end

  // Hazard overrides both sweeps; on H release each side reloads S1
  turn_pattern_gen_sweep u_left (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.L),
    .force_off (bus.H),
    .adv       (pre_step),
    .word      (bus.left_out)
  );

  turn_pattern_gen_sweep u_right (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.R),
    .force_off (bus.H),
    .adv       (pre_step),
    .word      (bus.right_out)
  );

endmodule

// File: tb/tb_turn_pattern_gen.sv
// Directed bench for turn_pattern_gen: TICK_DIV=4 main instance, TICK_DIV=1 second instance.
// Latency: expectations are counted in clock edges from each stimulus change.
// Backpressure: n/a.
module tb_turn_pattern_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [12:0] obs;

  turn_pattern_gen_if bus ();
  turn_pattern_gen_if bus1 ();

  turn_pattern_gen #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  turn_pattern_gen #(.TICK_DIV(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs, 13'b0);
    end
    obs = {bus1.left_out, bus1.right_out, bus1.haz_out, bus1.step};
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL reset_state_div1 got %b want %b", obs, 13'b0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // Run left for a while, then pull reset mid-cycle
    bus.L = 1'b1;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL reset_async got %b want %b", obs, 13'b0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b001, 3'b000, 6'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release_reload got %b want %b", obs, {3'b001, 3'b000, 6'b0, 1'b0});
    end
    bus.L = 1'b0;
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL reset_release_off got %b want %b", obs, 13'b0);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      tick();
      obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
      checks++;
      if (obs !== 13'b0) begin
        errors++;
        $display("FAIL idle cycle %0d got %b want %b", i, obs, 13'b0);
      end
    end
  endtask

  task automatic test_left_sweep();
    logic [2:0] seq [4];
    logic [2:0] prev;
    seq = '{3'b011, 3'b111, 3'b000, 3'b001};
    bus.L = 1'b1;
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b001, 3'b000, 6'b0, 1'b0}) begin
      errors++;
      $display("FAIL left_load got %b want %b", obs, {3'b001, 3'b000, 6'b0, 1'b0});
    end
    prev = 3'b001;
    for (int i = 0; i < 4; i++) begin
      repeat (3) tick();
      obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
      checks++;
      if (obs !== {prev, 3'b000, 6'b0, 1'b0}) begin
        errors++;
        $display("FAIL left_hold %0d got %b want %b", i, obs, {prev, 3'b000, 6'b0, 1'b0});
      end
      tick();
      obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
      checks++;
      if (obs !== {seq[i], 3'b000, 6'b0, 1'b1}) begin
        errors++;
        $display("FAIL left_step %0d got %b want %b", i, obs, {seq[i], 3'b000, 6'b0, 1'b1});
      end
      prev = seq[i];
    end
    bus.L = 1'b0;
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL left_release got %b want %b", obs, 13'b0);
    end
  endtask

  task automatic test_hazard();
    bus.L = 1'b1;
    bus.R = 1'b1;
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b001, 3'b001, 6'b0, 1'b0}) begin
      errors++;
      $display("FAIL both_load got %b want %b", obs, {3'b001, 3'b001, 6'b0, 1'b0});
    end
    repeat (4) tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b011, 3'b011, 6'b0, 1'b1}) begin
      errors++;
      $display("FAIL both_lockstep got %b want %b", obs, {3'b011, 3'b011, 6'b0, 1'b1});
    end
    // Hazard override, just after a step
    bus.H = 1'b1;
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b000, 3'b000, 6'b010101, 1'b0}) begin
      errors++;
      $display("FAIL haz_load got %b want %b", obs, {3'b000, 3'b000, 6'b010101, 1'b0});
    end
    repeat (3) tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b000, 3'b000, 6'b101010, 1'b1}) begin
      errors++;
      $display("FAIL haz_b got %b want %b", obs, {3'b000, 3'b000, 6'b101010, 1'b1});
    end
    repeat (4) tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b000, 3'b000, 6'b010101, 1'b1}) begin
      errors++;
      $display("FAIL haz_a_again got %b want %b", obs, {3'b000, 3'b000, 6'b010101, 1'b1});
    end
    // Hazard release with only R still held
    bus.H = 1'b0;
    bus.L = 1'b0;
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b000, 3'b001, 6'b0, 1'b0}) begin
      errors++;
      $display("FAIL haz_release got %b want %b", obs, {3'b000, 3'b001, 6'b0, 1'b0});
    end
    repeat (3) tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b000, 3'b011, 6'b0, 1'b1}) begin
      errors++;
      $display("FAIL haz_release_grid got %b want %b", obs, {3'b000, 3'b011, 6'b0, 1'b1});
    end
    bus.R = 1'b0;
    tick();
  endtask

  task automatic test_late_join();
    bus.L = 1'b1;
    tick();
    tick();
    bus.R = 1'b1;
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b001, 3'b001, 6'b0, 1'b0}) begin
      errors++;
      $display("FAIL late_join_load got %b want %b", obs, {3'b001, 3'b001, 6'b0, 1'b0});
    end
    tick();
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== {3'b011, 3'b011, 6'b0, 1'b1}) begin
      errors++;
      $display("FAIL late_join_step got %b want %b", obs, {3'b011, 3'b011, 6'b0, 1'b1});
    end
    bus.L = 1'b0;
    bus.R = 1'b0;
    tick();
    obs = {bus.left_out, bus.right_out, bus.haz_out, bus.step};
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL late_join_off got %b want %b", obs, 13'b0);
    end
  endtask

  task automatic test_tick_div1();
    logic [2:0] seq [4];
    seq = '{3'b011, 3'b111, 3'b000, 3'b001};
    bus1.L = 1'b1;
    tick();
    obs = {bus1.left_out, bus1.right_out, bus1.haz_out, bus1.step};
    checks++;
    if (obs !== {3'b001, 3'b000, 6'b0, 1'b0}) begin
      errors++;
      $display("FAIL div1_load got %b want %b", obs, {3'b001, 3'b000, 6'b0, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {bus1.left_out, bus1.right_out, bus1.haz_out, bus1.step};
      checks++;
      if (obs !== {seq[i], 3'b000, 6'b0, 1'b1}) begin
        errors++;
        $display("FAIL div1_step %0d got %b want %b", i, obs, {seq[i], 3'b000, 6'b0, 1'b1});
      end
    end
    bus1.L = 1'b0;
    tick();
    obs = {bus1.left_out, bus1.right_out, bus1.haz_out, bus1.step};
    checks++;
    if (obs !== 13'b0) begin
      errors++;
      $display("FAIL div1_off got %b want %b", obs, 13'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.L  = 1'b0;
    bus.H  = 1'b0;
    bus.R  = 1'b0;
    bus1.L = 1'b0;
    bus1.H = 1'b0;
    bus1.R = 1'b0;
    test_reset();
    test_idle();
    test_left_sweep();
    test_hazard();
    test_late_join();
    test_tick_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
